neuron_layer_sequencer: RTL and testbench
=========================================

// Module: neuron_layer_sequencer
// PURPOSE
//  Initiator side of the serial-neuron request/response protocol. Drives one serial MAC neuron
//  through NUM_NEURONS operations for one input vector. Per neuron: fetches its weight row and
//  bias from a sync-read weight memory, issues in_valid/x/w/bias, then captures the out_valid
//  result pulse. Presents the assembled layer vector on a valid/ready output port.
// PARAMETERS
//  NUM_INPUTS   8   elements per input vector (must match the neuron)
//  NUM_NEURONS  4   neurons (weight rows) per layer, >=1
//  X_W          8   signed input element width
//  W_W          8   signed weight width
//  B_W          32  signed bias width
//  OUT_W        16  signed neuron result width
//  IDX_W        derived localparam, max(1,clog2(NUM_NEURONS))
// PORTS
//  clk            in   1                  clock
//  rst_n          in   1                  asynchronous, active-low reset
//  vec_valid      in   1                  input vector offered
//  vec_ready      out  1                  1 iff state==IDLE
//  vec_x          in   NUM_INPUTS*X_W     input vector, element 0 in LSBs
//  wmem_rd_en     out  1                  weight-memory read strobe
//  wmem_addr      out  IDX_W              row index = current neuron
//  wmem_w         in   NUM_INPUTS*W_W     row data, valid the cycle after rd_en
//  wmem_bias      in   B_W                row bias, same timing as wmem_w
//  neu_in_valid   out  1                  request to neuron
//  neu_in_ready   in   1                  neuron accepts request
//  neu_x_flat     out  NUM_INPUTS*X_W     latched vector
//  neu_w_flat     out  NUM_INPUTS*W_W     latched weight row
//  neu_bias       out  B_W                latched bias
//  neu_out_valid  in   1                  1-cycle result pulse (no backpressure)
//  neu_out_data   in   OUT_W              result
//  lay_valid      out  1                  layer result available
//  lay_ready      in   1                  downstream accepts layer result
//  lay_y_flat     out  NUM_NEURONS*OUT_W  results, neuron 0 in LSBs
//  busy           out  1                  state!=IDLE
//  err_unexp      out  1                  1-cycle pulse: neu_out_valid outside WAIT
// BEHAVIOUR
//  FSM states: IDLE, FETCH, LOAD, ISSUE, WAIT, DONE. All control outputs are decoded from the
//  state flop only: wmem_rd_en=FETCH, neu_in_valid=ISSUE, lay_valid=DONE.
//  Reset: state=IDLE, idx=0, all data registers=0, err_unexp=0, all outputs 0 except vec_ready=1.
//  IDLE: on vec_valid&vec_ready, latch vec_x, set idx=0, go to FETCH.
//  FETCH (1 cycle): wmem_addr=idx, go to LOAD.
//  LOAD (1 cycle): capture wmem_w and wmem_bias, go to ISSUE.
//  ISSUE: hold neu_in_valid=1 with x/w/bias stable until neu_in_ready=1, then go to WAIT.
//  WAIT: on neu_out_valid, write neu_out_data into slot idx.
//   - If idx==NUM_NEURONS-1, go to DONE.
//   - Otherwise idx++, go to FETCH.
//  DONE: hold lay_valid=1 with lay_y_flat stable until lay_ready=1, then go to IDLE.
//   A new vector can be accepted on the cycle after that handshake.
//  Latency: overhead is 3 cycles per neuron (FETCH, LOAD, ISSUE with immediate ready) plus
//   neuron latency. The layer result appears 1 cycle after the last capture.
//  err_unexp pulses for 1 cycle on a neu_out_valid outside WAIT. That pulse is ignored: no slot
//   write, no state change.
//  lay_y_flat is meaningful only while lay_valid=1. Slots are overwritten during the next vector.
//  NUM_NEURONS=1: idx stays 0 and DONE follows the first capture.
//  idx never wraps: it is reset to 0 at each vector accept.
//  rst_n mid-operation: immediately returns to IDLE with all outputs at reset values. The neuron
//   shares rst_n, so no stale result can arrive.
//  No combinational path from any input to any output, except vec_ready/busy (state-derived).
// TESTING (bench pairs the block with the default serial neuron, ReLU on)
//  1. x=all 16, row n weights all 16*(n+1), bias 0
//     -> wmem_addr sequence 0,1,2,3; lay_y_flat = {8192,6144,4096,2048}; lay_valid 1 cycle
//     later with lay_ready=1.
//  2. neu_in_ready low 5 cycles in ISSUE -> neu_in_valid held and x/w/bias constant.
//     lay_ready low 10 cycles -> lay_valid held, lay_y_flat constant, vec_ready=0.
//  3. Forced neu_out_valid during FETCH -> err_unexp high exactly 1 cycle, slots and state
//     unchanged, final results still match test 1.
//  4. vec_valid held with 2 different vectors back to back -> second accepted the cycle after
//     the lay handshake, both results correct.
//  5. Row 0 weights all -16 (ReLU clamps), row 1 bias 0x100 with weights 0 -> slot0=0, slot1=256.
//  6. rst_n pulsed low during WAIT of neuron 2 -> next cycle: IDLE, vec_ready=1,
//     neu_in_valid=0, lay_valid=0, lay_y_flat=0. A full vector afterwards completes correctly.

Source files
------------

// File: rtl/neuron_layer_sequencer.sv
// Drives one serial MAC neuron through a layer of weight rows for a single input vector
// and presents the assembled layer result on a valid/ready port.
module neuron_layer_sequencer #(
    parameter  int NUM_INPUTS  = 8,
    parameter  int NUM_NEURONS = 4,
    parameter  int X_W         = 8,
    parameter  int W_W         = 8,
    parameter  int B_W         = 32,
    parameter  int OUT_W       = 16,
    localparam int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         vec_valid,
    output logic                         vec_ready,
    input  logic [NUM_INPUTS*X_W-1:0]    vec_x,
    output logic                         wmem_rd_en,
    output logic [IDX_W-1:0]             wmem_addr,
    input  logic [NUM_INPUTS*W_W-1:0]    wmem_w,
    input  logic [B_W-1:0]               wmem_bias,
    output logic                         neu_in_valid,
    input  logic                         neu_in_ready,
    output logic [NUM_INPUTS*X_W-1:0]    neu_x_flat,
    output logic [NUM_INPUTS*W_W-1:0]    neu_w_flat,
    output logic [B_W-1:0]               neu_bias,
    input  logic                         neu_out_valid,
    input  logic [OUT_W-1:0]             neu_out_data,
    output logic                         lay_valid,
    input  logic                         lay_ready,
    output logic [NUM_NEURONS*OUT_W-1:0] lay_y_flat,
    output logic                         busy,
    output logic                         err_unexp
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t                         state;
    state_t                         state_next;
    logic [IDX_W-1:0]               idx;
    logic [NUM_INPUTS*X_W-1:0]      x_reg;
    logic [NUM_INPUTS*W_W-1:0]      w_reg;
    logic [B_W-1:0]                 b_reg;
    logic [NUM_NEURONS*OUT_W-1:0]   y_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (vec_valid)     state_next = FETCH;
            FETCH:                      state_next = LOAD;
            LOAD:                       state_next = ISSUE;
            ISSUE:   if (neu_in_ready)  state_next = WAIT;
            WAIT:    if (neu_out_valid) state_next = (idx == LAST_IDX) ? DONE : FETCH;
            DONE:    if (lay_ready)     state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Result pulses outside WAIT are flagged only; they never touch slots or the index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            x_reg     <= '0;
            w_reg     <= '0;
            b_reg     <= '0;
            y_reg     <= '0;
            err_unexp <= 1'b0;
        end else begin
            err_unexp <= neu_out_valid && (state != WAIT);
            case (state)
                IDLE: begin
                    if (vec_valid) begin
                        x_reg <= vec_x;
                        idx   <= '0;
                    end
                end
                LOAD: begin
                    w_reg <= wmem_w;
                    b_reg <= wmem_bias;
                end
                WAIT: begin
                    if (neu_out_valid) begin
                        y_reg[idx*OUT_W +: OUT_W] <= neu_out_data;
                        if (idx != LAST_IDX) begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign vec_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign wmem_rd_en   = (state == FETCH);
    assign neu_in_valid = (state == ISSUE);
    assign lay_valid    = (state == DONE);
    assign wmem_addr    = idx;
    assign neu_x_flat   = x_reg;
    assign neu_w_flat   = w_reg;
    assign neu_bias     = b_reg;
    assign lay_y_flat   = y_reg;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Directed bench for neuron_layer_sequencer with a sync-read weight memory and a
// behavioural serial ReLU neuron attached.
module tb_neuron_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vec_valid = 1'b0;
    logic        vec_ready;
    logic [63:0] vec_x = '0;
    logic        wmem_rd_en;
    logic [1:0]  wmem_addr;
    logic [63:0] wmem_w;
    logic [31:0] wmem_bias;
    logic        neu_in_valid;
    logic        neu_in_ready;
    logic [63:0] neu_x_flat;
    logic [63:0] neu_w_flat;
    logic [31:0] neu_bias;
    logic        neu_out_valid;
    logic [15:0] neu_out_data;
    logic        lay_valid;
    logic        lay_ready = 1'b1;
    logic [63:0] lay_y_flat;
    logic        busy;
    logic        err_unexp;

    int tests_run = 0;
    int tests_failed = 0;

    logic [63:0] row_w [4];
    logic [31:0] row_b [4];
    int unsigned addr_log [$];

    logic        ready_en = 1'b1;
    logic        inject_ov = 1'b0;
    logic        model_ov;
    int          pend;
    logic [15:0] res_q;

    localparam logic [63:0] Y_BASE = 64'h2000_1800_1000_0800;
    localparam logic [63:0] Y_HALF = 64'h1000_0C00_0800_0400;
    localparam logic [63:0] Y_T5   = 64'h2000_1800_0100_0000;

    always #5 clk = ~clk;

    neuron_layer_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vec_valid    (vec_valid),
        .vec_ready    (vec_ready),
        .vec_x        (vec_x),
        .wmem_rd_en   (wmem_rd_en),
        .wmem_addr    (wmem_addr),
        .wmem_w       (wmem_w),
        .wmem_bias    (wmem_bias),
        .neu_in_valid (neu_in_valid),
        .neu_in_ready (neu_in_ready),
        .neu_x_flat   (neu_x_flat),
        .neu_w_flat   (neu_w_flat),
        .neu_bias     (neu_bias),
        .neu_out_valid(neu_out_valid),
        .neu_out_data (neu_out_data),
        .lay_valid    (lay_valid),
        .lay_ready    (lay_ready),
        .lay_y_flat   (lay_y_flat),
        .busy         (busy),
        .err_unexp    (err_unexp)
    );

    function automatic logic [63:0] fill8(input logic [7:0] v);
        return {8{v}};
    endfunction

    function automatic logic [15:0] neuron_calc(input logic [63:0] x, input logic [63:0] w,
                                                input logic [31:0] b);
        int acc;
        logic [31:0] res;
        acc = int'($signed(b));
        for (int i = 0; i < 8; i++) begin
            acc += int'($signed(x[i*8 +: 8])) * int'($signed(w[i*8 +: 8]));
        end
        if (acc < 0) acc = 0;
        if (acc > 32767) acc = 32767;
        res = acc;
        return res[15:0];
    endfunction

    // Weight memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (wmem_rd_en) begin
            wmem_w    <= row_w[wmem_addr];
            wmem_bias <= row_b[wmem_addr];
        end
    end

    // Serial neuron: fixed 4-cycle latency, one request in flight, shares rst_n.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend         <= 0;
            model_ov     <= 1'b0;
            res_q        <= '0;
            neu_out_data <= '0;
        end else begin
            model_ov <= 1'b0;
            if (pend != 0) begin
                pend <= pend - 1;
                if (pend == 1) begin
                    model_ov     <= 1'b1;
                    neu_out_data <= res_q;
                end
            end else if (neu_in_valid && neu_in_ready) begin
                res_q <= neuron_calc(neu_x_flat, neu_w_flat, neu_bias);
                pend  <= 4;
            end
        end
    end

    assign neu_in_ready  = ready_en && (pend == 0);
    assign neu_out_valid = model_ov | inject_ov;

    always @(negedge clk) begin
        if (wmem_rd_en) addr_log.push_back(32'(wmem_addr));
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic set_rows_default();
        for (int n = 0; n < 4; n++) begin
            row_w[n] = fill8(8'(16 * (n + 1)));
            row_b[n] = '0;
        end
    endtask

    task automatic applyStimulus(input logic [63:0] x);
        int n = 0;
        while (!vec_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!vec_ready) checkOutput("accept_timeout", 64'(vec_ready), 64'd1);
        vec_x     = x;
        vec_valid = 1'b1;
        @(negedge clk);
        vec_valid = 1'b0;
    endtask

    task automatic wait_lay(output logic [63:0] y, output logic prev_ov);
        int n = 0;
        prev_ov = 1'b0;
        while (!lay_valid && n < 300) begin
            prev_ov = neu_out_valid;
            @(negedge clk);
            n++;
        end
        if (!lay_valid) checkOutput("lay_timeout", 64'(lay_valid), 64'd1);
        y = lay_y_flat;
    endtask

    task automatic check_addr_log(input string tag);
        checkOutput({tag, "_addr_count"}, 64'(addr_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i),
                        (i < addr_log.size()) ? 64'(addr_log[i]) : 64'hFFFF, 64'(i));
        end
    endtask

    initial begin
        logic [63:0] y;
        logic        prev_ov;
        int          n;

        set_rows_default();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_vec_ready", 64'(vec_ready), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_rd_en", 64'(wmem_rd_en), 64'd0);
        checkOutput("rst_in_valid", 64'(neu_in_valid), 64'd0);
        checkOutput("rst_lay_valid", 64'(lay_valid), 64'd0);
        checkOutput("rst_err", 64'(err_unexp), 64'd0);
        checkOutput("rst_y", lay_y_flat, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: basic layer
        addr_log.delete();
        applyStimulus(fill8(8'd16));
        wait_lay(y, prev_ov);
        checkOutput("t1_y", y, Y_BASE);
        checkOutput("t1_latency", 64'(prev_ov), 64'd1);
        check_addr_log("t1");
        @(negedge clk);
        checkOutput("t1_lay_drop", 64'(lay_valid), 64'd0);
        checkOutput("t1_idle", 64'(vec_ready), 64'd1);

        // Test 2: neuron and downstream backpressure
        ready_en  = 1'b0;
        lay_ready = 1'b0;
        applyStimulus(fill8(8'd16));
        n = 0;
        while (!neu_in_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t2_issue_seen", 64'(neu_in_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t2_in_valid_hold", 64'(neu_in_valid), 64'd1);
            checkOutput("t2_x_hold", neu_x_flat, fill8(8'd16));
            checkOutput("t2_w_hold", neu_w_flat, fill8(8'd16));
            checkOutput("t2_bias_hold", 64'(neu_bias), 64'd0);
        end
        ready_en = 1'b1;
        wait_lay(y, prev_ov);
        checkOutput("t2_y", y, Y_BASE);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("t2_lay_hold", 64'(lay_valid), 64'd1);
            checkOutput("t2_y_hold", lay_y_flat, Y_BASE);
            checkOutput("t2_vec_ready_low", 64'(vec_ready), 64'd0);
        end
        lay_ready = 1'b1;
        @(negedge clk);
        checkOutput("t2_lay_drop", 64'(lay_valid), 64'd0);

        // Test 3: stray result pulse during FETCH
        addr_log.delete();
        applyStimulus(fill8(8'd16));
        checkOutput("t3_in_fetch", 64'(wmem_rd_en), 64'd1);
        inject_ov = 1'b1;
        @(negedge clk);
        inject_ov = 1'b0;
        checkOutput("t3_err_high", 64'(err_unexp), 64'd1);
        checkOutput("t3_in_load", 64'({wmem_rd_en, neu_in_valid, busy}), 64'b001);
        @(negedge clk);
        checkOutput("t3_err_low", 64'(err_unexp), 64'd0);
        checkOutput("t3_in_issue", 64'(neu_in_valid), 64'd1);
        checkOutput("t3_slots_kept", lay_y_flat, Y_BASE);
        wait_lay(y, prev_ov);
        checkOutput("t3_y", y, Y_BASE);
        check_addr_log("t3");
        @(negedge clk);

        // Test 4: back-to-back vectors with vec_valid held
        vec_x     = fill8(8'd16);
        vec_valid = 1'b1;
        @(negedge clk);
        vec_x = fill8(8'd8);
        wait_lay(y, prev_ov);
        checkOutput("t4_y_first", y, Y_BASE);
        @(negedge clk);
        checkOutput("t4_idle_gap", 64'(vec_ready), 64'd1);
        checkOutput("t4_lay_drop", 64'(lay_valid), 64'd0);
        @(negedge clk);
        checkOutput("t4_second_accept", 64'({busy, wmem_rd_en}), 64'b11);
        vec_valid = 1'b0;
        wait_lay(y, prev_ov);
        checkOutput("t4_y_second", y, Y_HALF);
        @(negedge clk);

        // Test 5: ReLU clamp on row 0, bias-only row 1
        row_w[0] = fill8(8'hF0);
        row_w[1] = '0;
        row_b[1] = 32'h100;
        applyStimulus(fill8(8'd16));
        wait_lay(y, prev_ov);
        checkOutput("t5_slot0", 64'(y[15:0]), 64'd0);
        checkOutput("t5_slot1", 64'(y[31:16]), 64'd256);
        checkOutput("t5_y", y, Y_T5);
        @(negedge clk);
        set_rows_default();

        // Test 6: reset during WAIT of neuron 2
        applyStimulus(fill8(8'd16));
        n = 0;
        while (!(neu_in_valid && neu_in_ready && wmem_addr == 2'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_reach_n2", 64'(wmem_addr), 64'd2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t6_vec_ready", 64'(vec_ready), 64'd1);
        checkOutput("t6_busy", 64'(busy), 64'd0);
        checkOutput("t6_in_valid", 64'(neu_in_valid), 64'd0);
        checkOutput("t6_lay_valid", 64'(lay_valid), 64'd0);
        checkOutput("t6_y_zero", lay_y_flat, 64'd0);
        checkOutput("t6_addr_zero", 64'(wmem_addr), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        addr_log.delete();
        applyStimulus(fill8(8'd16));
        wait_lay(y, prev_ov);
        checkOutput("t6_y_after", y, Y_BASE);
        check_addr_log("t6");
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

endmodule
